// File: rtl/noc_link_vc_buffer_if.sv
// Link-side bundle of the multi-VC receive buffer: write side (tx_*) and
// show-ahead read side (rx_*). The slave modport is the buffer itself.
interface noc_link_vc_buffer_if #(
   parameter int HDR_W  = 8,
   parameter int PAY_W  = 16,
   parameter int NUM_VC = 2,
   parameter int VCW    = 1
);
   logic              tx_wrreq_i;
   logic [VCW-1:0]    tx_vc_i;
   logic [HDR_W-1:0]  tx_header_i;
   logic [PAY_W-1:0]  tx_payload_i;
   logic [NUM_VC-1:0] tx_stall_o;
   logic [NUM_VC-1:0] tx_almost_full_o;
   logic              tx_overflow_o;
   logic              rx_rdreq_i;
   logic [HDR_W-1:0]  rx_header_o;
   logic [PAY_W-1:0]  rx_payload_o;
   logic [VCW-1:0]    rx_vc_o;
   logic              rx_fifo_empty_o;

   modport slave (
      input  tx_wrreq_i, tx_vc_i, tx_header_i, tx_payload_i, rx_rdreq_i,
      output tx_stall_o, tx_almost_full_o, tx_overflow_o,
      output rx_header_o, rx_payload_o, rx_vc_o, rx_fifo_empty_o
   );

   modport master (
      output tx_wrreq_i, tx_vc_i, tx_header_i, tx_payload_i, rx_rdreq_i,
      input  tx_stall_o, tx_almost_full_o, tx_overflow_o,
      input  rx_header_o, rx_payload_o, rx_vc_o, rx_fifo_empty_o
   );
endinterface

// File: rtl/noc_link_vc_buffer.sv
// Multi-VC NoC link receive buffer: one FIFO per virtual channel, one VC
// granted per cycle into a show-ahead output register.
module noc_link_vc_buffer #(
   parameter int NOC_HEADER_SIZE  = 8,
   parameter int NOC_PAYLOAD_SIZE = 16,
   parameter int NUM_VC           = 2,
   parameter int VC_AWIDTH        = 2,
   parameter int AF_MARGIN        = 1,
   parameter int ARB_MODE         = 0,
   parameter int VCW              = (NUM_VC > 1) ? $clog2(NUM_VC) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_q_i,
   noc_link_vc_buffer_if.slave   link
);
   localparam int DEPTH  = 1 << VC_AWIDTH;
   localparam int DATA_W = NOC_HEADER_SIZE + NOC_PAYLOAD_SIZE;
   localparam logic [VC_AWIDTH:0] FULL_LVL = (VC_AWIDTH + 1)'(DEPTH);
   localparam logic [VC_AWIDTH:0] AF_LVL   = (VC_AWIDTH + 1)'(DEPTH - AF_MARGIN);
   localparam logic [VCW-1:0]     LAST_VC  = VCW'(NUM_VC - 1);

   logic [DATA_W-1:0]      mem [NUM_VC][DEPTH];
   logic [VC_AWIDTH:0]     wptr [NUM_VC];
   logic [VC_AWIDTH:0]     rptr [NUM_VC];
   logic [VC_AWIDTH:0]     count [NUM_VC];
   logic [NUM_VC-1:0]      full;
   logic [NUM_VC-1:0]      almost_full;
   logic [NUM_VC-1:0]      nonempty;
   logic                   any_nonempty;
   logic                   vc_ok;
   logic                   wr_ok;
   logic                   load;
   logic                   found;
   logic [VCW-1:0]         cand;
   logic [VCW-1:0]         grant;
   logic [VCW-1:0]         last_grant;
   logic                   overflow;
   logic                   rx_empty;
   logic [NOC_HEADER_SIZE-1:0]  rx_header;
   logic [NOC_PAYLOAD_SIZE-1:0] rx_payload;
   logic [VCW-1:0]              rx_vc;

   // Occupancy flags decoded from registered pointers only (no same-cycle pop credit).
   always_comb begin
      full        = '0;
      almost_full = '0;
      nonempty    = '0;
      for (int v = 0; v < NUM_VC; v++) begin
         count[v]       = wptr[v] - rptr[v];
         full[v]        = (count[v] == FULL_LVL);
         almost_full[v] = (count[v] >= AF_LVL);
         nonempty[v]    = (count[v] != '0);
      end
   end

   assign any_nonempty = |nonempty;
   // Out-of-range VC indices are treated like a write to a full VC: dropped and flagged.
   assign vc_ok = (int'(link.tx_vc_i) < NUM_VC);
   assign wr_ok = link.tx_wrreq_i & vc_ok & ~full[link.tx_vc_i];
   assign load  = (rx_empty | link.rx_rdreq_i) & any_nonempty;

   // Grant selection: round-robin from last_grant+1, or lowest index first.
   always_comb begin
      grant = '0;
      cand  = '0;
      found = 1'b0;
      for (int i = 0; i < NUM_VC; i++) begin
         if (ARB_MODE == 0) cand = VCW'((int'(last_grant) + 1 + i) % NUM_VC);
         else               cand = VCW'(i);
         if (!found && nonempty[cand]) begin
            grant = cand;
            found = 1'b1;
         end
      end
   end

   // Flit storage; contents are don't-care until written, so no reset.
   always_ff @(posedge clk_i) begin
      if (wr_ok)
         mem[link.tx_vc_i][wptr[link.tx_vc_i][VC_AWIDTH-1:0]] <= {link.tx_header_i, link.tx_payload_i};
   end

   // Pointer and arbitration state; a write and a pop on the same VC both apply.
   always_ff @(posedge clk_i or negedge rst_q_i) begin
      if (!rst_q_i) begin
         for (int v = 0; v < NUM_VC; v++) begin
            wptr[v] <= '0;
            rptr[v] <= '0;
         end
         last_grant <= LAST_VC;
         overflow   <= 1'b0;
      end else begin
         overflow <= link.tx_wrreq_i & ~wr_ok;
         for (int v = 0; v < NUM_VC; v++) begin
            if (wr_ok && (link.tx_vc_i == VCW'(v))) wptr[v] <= wptr[v] + 1'b1;
            if (load && (grant == VCW'(v)))         rptr[v] <= rptr[v] + 1'b1;
         end
         if (load) last_grant <= grant;
      end
   end

   // Show-ahead output register: loads the granted head, holds data when idle.
   always_ff @(posedge clk_i or negedge rst_q_i) begin
      if (!rst_q_i) begin
         rx_empty   <= 1'b1;
         rx_header  <= '0;
         rx_payload <= '0;
         rx_vc      <= '0;
      end else if (load) begin
         rx_empty                <= 1'b0;
         {rx_header, rx_payload} <= mem[grant][rptr[grant][VC_AWIDTH-1:0]];
         rx_vc                   <= grant;
      end else if (link.rx_rdreq_i) begin
         rx_empty <= 1'b1;
      end
   end

   assign link.tx_stall_o       = full;
   assign link.tx_almost_full_o = almost_full;
   assign link.tx_overflow_o    = overflow;
   assign link.rx_header_o      = rx_header;
   assign link.rx_payload_o     = rx_payload;
   assign link.rx_vc_o          = rx_vc;
   assign link.rx_fifo_empty_o  = rx_empty;
endmodule
